tempo_clock_div: RTL
====================

// Module: tempo_clock_div
// PURPOSE
//  Multi-channel programmable clock divider for the piano datapath (note timing, beat/tempo clocks).
//  Each channel turns the 100 MHz system clock into a square enable-clock plus a one-cycle tick.
//  Each channel's period can be reloaded at runtime and takes effect glitch-free on the next period boundary.
//  Used by the playback and metronome logic in place of fixed per-rate dividers.
// PARAMETERS
//  CNT_W          32          counter/period width in bits
//  NCH            2           number of independent channels
//  DEFAULT_PERIOD 75_000_000  reset period in clk cycles (0.75 s at 100 MHz); must be >= 2
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst          in   1          synchronous active-low reset
//  en           in   NCH        per-channel run enable
//  load         in   NCH        per-channel period-load strobe, 1 cycle
//  period_in    in   NCH*CNT_W  new period; channel i uses bits [i*CNT_W +: CNT_W]
//  sync_restart in   1          realign all channels to phase 0
//  clk_out      out  NCH        divided square clock
//  tick         out  NCH        1-cycle pulse, once per period
//  period_q     out  NCH*CNT_W  period currently in effect, per channel
// BEHAVIOUR
//  - Reset: rst sampled low at a clk edge. cnt=0; period_q=DEFAULT_PERIOD; pending flag cleared; clk_out=0; tick=0.
//    Reset has priority over every other input. The same applies when rst is asserted mid-period.
//  - Per-channel state: cnt[CNT_W] (0..P-1); active period P (= period_q); pending period PN; pending flag pv.
//  - Period load (load[i]=1):
//    - PN <= max(period_in slice, 2); values 0 and 1 are clamped to 2.
//    - pv <= 1.
//    - Repeated loads before pv is consumed: the last one wins.
//  - Running (en[i]=1):
//    - cnt increments by 1 each cycle.
//    - At cnt==P-1 (wrap): cnt <= 0; tick <= 1 for exactly one cycle.
//    - At wrap, if pv (or load[i] in the same cycle): P <= PN (or the new clamped value); pv <= 0.
//      The new P governs the very next period. A load in the wrap cycle itself takes effect at that wrap.
//  - clk_out, registered:
//    - Set in the cycle after cnt==(P>>1)-1.
//    - Cleared in the cycle after cnt==P-1.
//    - Result: low P>>1 cycles, high P-(P>>1) cycles. For odd P the extra cycle is high.
//  - tick rises in the same cycle that clk_out falls. Both are registered outputs with 1-cycle latency from the cnt compare.
//  - Disabled (en[i]=0):
//    - Next edge: cnt=0, clk_out=0, tick=0.
//    - A pending or same-cycle load is applied immediately (P <= PN, pv <= 0).
//    - Raising en restarts from cnt=0; the first tick comes P cycles after the first enabled edge.
//  - sync_restart=1 (lower priority than rst, higher than en and wrap), applied to all channels:
//    - cnt=0, clk_out=0, tick=0.
//    - Pending loads applied.
//    - Channels with equal P stay phase-aligned afterwards.
//  - Channels are fully independent apart from rst and sync_restart.
//  - No arithmetic overflow: cnt never exceeds P-1 <= 2^CNT_W-2.
// TESTING (DEFAULT_PERIOD=10, NCH=2, CNT_W=8 for simulation)
//  1. Reset release, en=2'b01 -> ch0: tick every 10 cycles; clk_out low 5 / high 5; ch1 clk_out=0, tick=0.
//  2. load ch0 with period 7 mid-period (cnt=3) -> current period still ends at 10; following periods are 7 (low 3, high 4);
//     period_q reads 7 only after that wrap.
//  3. load ch0 with period 0 -> clamped to 2; clk_out toggles every cycle; one tick every 2 cycles.
//  4. Load issued in the wrap cycle (cnt==P-1) -> new period used for the immediately following period;
//     two loads (5, then 9) before a wrap -> 9 applied.
//  5. Both channels enabled, ch1 period 4; assert sync_restart -> both clk_out=0 next cycle;
//     ticks coincide every 20 cycles (LCM).
//  6. rst low for 1 cycle mid-period with a load pending -> all outputs 0; period_q=10; pending discarded;
//     first tick 10 cycles after release.

Source files
------------

// File: rtl/tempo_clock_div.sv
// Multi-channel programmable clock divider.
// Each channel makes a square divided clock and a one-cycle tick per period.
// A new period can be loaded at any time. It takes effect at the next period
// boundary, when the channel is disabled, or on a sync restart.

// One divider channel: counter, active/pending period, registered outputs.
module tempo_clock_div_ch #(
  parameter int                CNT_W          = 32,
  parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = CNT_W'(75_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             sync_restart,
  input  logic [CNT_W-1:0] period_in,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] period_q
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend;
  logic             pv;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] next_p;
  logic             wrap;
  logic             half_hit;

  // Periods below 2 cannot form a square wave, so they are raised to 2.
  assign load_val = (period_in < TWO) ? TWO : period_in;
  // Period used from the next boundary: same-cycle load beats pending beats current.
  assign next_p   = load ? load_val : (pv ? pend : period_q);
  // period_q >= 2 always, so neither subtraction can underflow.
  assign wrap     = (cnt == period_q - ONE);
  assign half_hit = (cnt == (period_q >> 1) - ONE);

  // Counter, period hand-over and registered clk_out/tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      period_q <= DEFAULT_PERIOD;
      pend     <= DEFAULT_PERIOD;
      pv       <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else if (sync_restart || !en) begin
      // Idle or realign: back to phase 0 and adopt any waiting period now.
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      period_q <= next_p;
      pv       <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b1;
      period_q <= next_p;
      pv       <= 1'b0;
    end else begin
      cnt  <= cnt + ONE;
      tick <= 1'b0;
      if (half_hit) clk_out <= 1'b1;
      if (load) begin
        pend <= load_val;
        pv   <= 1'b1;
      end
    end
  end
endmodule

// Top: NCH independent channels sharing reset and sync restart.
module tempo_clock_div #(
  parameter int          CNT_W          = 32,
  parameter int          NCH            = 2,
  parameter int unsigned DEFAULT_PERIOD = 75_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*CNT_W-1:0] period_in,
  input  logic                 sync_restart,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH*CNT_W-1:0] period_q
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tempo_clock_div_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (CNT_W'(DEFAULT_PERIOD))
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en           (en[i]),
      .load         (load[i]),
      .sync_restart (sync_restart),
      .period_in    (period_in[i*CNT_W +: CNT_W]),
      .clk_out      (clk_out[i]),
      .tick         (tick[i]),
      .period_q     (period_q[i*CNT_W +: CNT_W])
    );
  end
endmodule
